// File: rtl/pc_nzp_unit.sv
// Per-thread PC / NZP condition-code unit: resolves BRnzp in EXECUTE, commits PC and flags in UPDATE.
// Define PC_CALL_STACK_EN to build the CALL/RET return-address stack.
module pc_nzp_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [2:0]          core_state,
    input  logic [2:0]          alu_nzp,
    input  logic [2:0]          decoded_nzp,
    input  logic [PC_WIDTH-1:0] decoded_immediate,
    input  logic                decoded_nzp_write_enable,
    input  logic                decoded_pc_mux,
    input  logic                decoded_call,
    input  logic                decoded_ret,
    output logic [PC_WIDTH-1:0] current_pc,
    output logic [PC_WIDTH-1:0] next_pc,
    output logic [2:0]          nzp,
    output logic                stack_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_t;

    core_state_t         w_state;
    logic [PC_WIDTH-1:0] r_current_pc;
    logic [PC_WIDTH-1:0] r_next_pc;
    logic [2:0]          r_nzp;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_taken;
    logic [PC_WIDTH-1:0] w_target;

    assign w_state  = core_state_t'(core_state);
    assign w_pc_inc = r_current_pc + PC_WIDTH'(1);
    assign w_taken  = decoded_pc_mux && (|(r_nzp & decoded_nzp));

    assign current_pc = r_current_pc;
    assign next_pc    = r_next_pc;
    assign nzp        = r_nzp;

`ifdef PC_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]     r_sp;
    logic                r_executed;
    logic                r_stack_error;
    logic                w_push;
    logic                w_pop;
    logic                w_err;
    logic                w_full;
    logic [IDX_W-1:0]    w_top_idx;
    logic [IDX_W-1:0]    w_push_idx;

    assign w_full      = (r_sp == SP_W'(STACK_DEPTH));
    assign w_top_idx   = IDX_W'(r_sp - SP_W'(1));
    assign w_push_idx  = IDX_W'(r_sp);
    assign stack_error = r_stack_error;

    always_comb begin
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_err    = 1'b0;
        w_target = w_taken ? decoded_immediate : w_pc_inc;
        if (decoded_call && decoded_ret) begin
            w_err    = 1'b1;
            w_target = w_pc_inc;
        end else if (decoded_ret) begin
            if (r_sp != '0) begin
                w_pop    = 1'b1;
                w_target = r_stack[w_top_idx];
            end else begin
                w_err    = 1'b1;
                w_target = w_pc_inc;
            end
        end else if (decoded_call) begin
            w_target = decoded_immediate;
            if (w_full) w_err  = 1'b1;
            else        w_push = 1'b1;
        end
        // Held EXECUTE: stack already moved on the first cycle, so a pop result is kept, not re-read.
        if (r_executed) begin
            w_push = 1'b0;
            w_pop  = 1'b0;
            w_err  = 1'b0;
            if (decoded_ret && !decoded_call) w_target = r_next_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp          <= '0;
            r_executed    <= 1'b0;
            r_stack_error <= 1'b0;
        end else if (enable) begin
            if (w_state == S_EXECUTE) begin
                r_executed <= 1'b1;
                if (w_push) begin
                    r_stack[w_push_idx] <= w_pc_inc;
                    r_sp                <= r_sp + SP_W'(1);
                end
                if (w_pop) r_sp <= r_sp - SP_W'(1);
                if (w_err) r_stack_error <= 1'b1;
            end else if (w_state == S_UPDATE) begin
                r_executed <= 1'b0;
            end
        end
    end
`else
    logic w_unused_ok;

    assign w_target    = w_taken ? decoded_immediate : w_pc_inc;
    assign stack_error = 1'b0;
    assign w_unused_ok = &{1'b0, decoded_call, decoded_ret, STACK_DEPTH[0]};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_current_pc <= '0;
            r_next_pc    <= '0;
            r_nzp        <= '0;
        end else if (enable) begin
            case (w_state)
                S_EXECUTE: r_next_pc <= w_target;
                S_UPDATE: begin
                    r_current_pc <= r_next_pc;
                    if (decoded_nzp_write_enable) r_nzp <= alu_nzp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_nzp_unit.sv
// Directed-vector bench for pc_nzp_unit; stack vectors run when PC_CALL_STACK_EN is defined.
module tb_pc_nzp_unit;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_EXECUTE = 3'b101;
    localparam logic [2:0] ST_UPDATE  = 3'b110;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] core_state;
    logic [2:0] alu_nzp;
    logic [2:0] decoded_nzp;
    logic [7:0] decoded_immediate;
    logic       decoded_nzp_write_enable;
    logic       decoded_pc_mux;
    logic       decoded_call;
    logic       decoded_ret;
    logic [7:0] current_pc;
    logic [7:0] next_pc;
    logic [2:0] nzp;
    logic       stack_error;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    pc_nzp_unit #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .alu_nzp                  (alu_nzp),
        .decoded_nzp              (decoded_nzp),
        .decoded_immediate        (decoded_immediate),
        .decoded_nzp_write_enable (decoded_nzp_write_enable),
        .decoded_pc_mux           (decoded_pc_mux),
        .decoded_call             (decoded_call),
        .decoded_ret              (decoded_ret),
        .current_pc               (current_pc),
        .next_pc                  (next_pc),
        .nzp                      (nzp),
        .stack_error              (stack_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic [2:0] st);
        core_state = st;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        decoded_pc_mux           = 1'b0;
        decoded_nzp              = 3'b000;
        decoded_immediate        = 8'h00;
        decoded_nzp_write_enable = 1'b0;
        alu_nzp                  = 3'b000;
        decoded_call             = 1'b0;
        decoded_ret              = 1'b0;
    endtask

    // One instruction: EXECUTE with current controls, then UPDATE.
    task automatic instr();
        tick(ST_EXECUTE);
        tick(ST_UPDATE);
    endtask

    task automatic branch_to(input logic [7:0] tgt, input logic [2:0] mask);
        decoded_pc_mux    = 1'b1;
        decoded_nzp       = mask;
        decoded_immediate = tgt;
        instr();
        clear_ctl();
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        core_state = ST_IDLE;
        clear_ctl();
        tick(ST_IDLE);
        reset = 1'b0;
        repeat (20) tick(ST_IDLE);
        check("rst_cpc", current_pc, 0);
        check("rst_npc", next_pc, 0);
        check("rst_nzp", nzp, 0);
        check("rst_err", stack_error, 0);

        // Sequential advance
        tick(ST_EXECUTE);
        check("seq_npc1", next_pc, 1);
        check("seq_cpc_hold", current_pc, 0);
        tick(ST_UPDATE);
        check("seq_cpc1", current_pc, 1);
        instr();
        check("seq_cpc2", current_pc, 2);
        instr();
        check("seq_cpc3", current_pc, 3);

        // NZP capture and taken branch
        decoded_nzp_write_enable = 1'b1;
        alu_nzp = 3'b100;
        tick(ST_UPDATE);
        check("cap_nzp", nzp, 3'b100);
        clear_ctl();
        decoded_pc_mux = 1'b1; decoded_nzp = 3'b100; decoded_immediate = 8'h40;
        tick(ST_EXECUTE);
        check("br_npc", next_pc, 8'h40);
        tick(ST_UPDATE);
        check("br_cpc", current_pc, 8'h40);
        clear_ctl();

        // Wrap from 8'hFF
        branch_to(8'hFF, 3'b100);
        check("wrap_pre", current_pc, 8'hFF);
        tick(ST_EXECUTE);
        check("wrap_npc", next_pc, 8'h00);
        tick(ST_UPDATE);
        check("wrap_cpc", current_pc, 8'h00);

        // Not taken, and UPDATE without write enable
        decoded_nzp_write_enable = 1'b1;
        alu_nzp = 3'b010;
        tick(ST_UPDATE);
        clear_ctl();
        check("nzp_010", nzp, 3'b010);
        branch_to(8'h05, 3'b010);
        check("pc5", current_pc, 5);
        decoded_pc_mux = 1'b1; decoded_nzp = 3'b101; decoded_immediate = 8'h77;
        tick(ST_EXECUTE);
        check("nt_npc", next_pc, 6);
        clear_ctl();
        alu_nzp = 3'b001;
        tick(ST_UPDATE);
        check("nowr_nzp", nzp, 3'b010);
        check("nt_cpc", current_pc, 6);
        clear_ctl();

        // Mask 000 never branches, 111 always does
        decoded_pc_mux = 1'b1; decoded_nzp = 3'b000; decoded_immediate = 8'h99;
        tick(ST_EXECUTE);
        check("mask000", next_pc, 7);
        decoded_nzp = 3'b111; decoded_immediate = 8'h20;
        tick(ST_EXECUTE);
        check("mask111", next_pc, 8'h20);
        tick(ST_UPDATE);
        check("mask111_cpc", current_pc, 8'h20);
        clear_ctl();

        // Non-one-hot flags stored as-is; branch is a bitwise AND (held EXECUTE recomputes)
        decoded_nzp_write_enable = 1'b1; alu_nzp = 3'b011;
        tick(ST_UPDATE);
        clear_ctl();
        check("nzp_011", nzp, 3'b011);
        decoded_pc_mux = 1'b1; decoded_nzp = 3'b100; decoded_immediate = 8'h30;
        tick(ST_EXECUTE);
        check("and_nt", next_pc, 8'h21);
        decoded_nzp = 3'b001;
        tick(ST_EXECUTE);
        check("and_t", next_pc, 8'h30);
        clear_ctl();

        // Enable low holds everything
        enable = 1'b0;
        decoded_pc_mux = 1'b1; decoded_nzp = 3'b111; decoded_immediate = 8'h55;
        decoded_nzp_write_enable = 1'b1; alu_nzp = 3'b100;
        instr();
        check("en0_npc", next_pc, 8'h30);
        check("en0_cpc", current_pc, 8'h20);
        check("en0_nzp", nzp, 3'b011);
        clear_ctl();
        enable = 1'b1;
        tick(ST_UPDATE);
        check("en1_cpc", current_pc, 8'h30);

`ifndef PC_CALL_STACK_EN
        // Without the stack, CALL/RET are ignored
        decoded_call = 1'b1; decoded_immediate = 8'h99;
        tick(ST_EXECUTE);
        check("call_ign", next_pc, 8'h31);
        decoded_call = 1'b0; decoded_ret = 1'b1;
        tick(ST_EXECUTE);
        check("ret_ign", next_pc, 8'h31);
        check("err_tied", stack_error, 0);
        clear_ctl();
`endif

        // Reset mid-instruction overrides enable=0 and UPDATE
        tick(ST_EXECUTE);
        enable = 1'b0; reset = 1'b1;
        tick(ST_UPDATE);
        reset = 1'b0; enable = 1'b1;
        check("mid_rst_cpc", current_pc, 0);
        check("mid_rst_npc", next_pc, 0);
        check("mid_rst_nzp", nzp, 0);
        tick(ST_IDLE);

`ifdef PC_CALL_STACK_EN
        instr();
        instr();
        check("stk_pc2", current_pc, 2);
        for (int i = 0; i < 4; i++) begin
            decoded_call = 1'b1; decoded_immediate = 8'(3 + i);
            instr();
            check("call_cpc", current_pc, 3 + i);
        end
        check("call_noerr", stack_error, 0);
        decoded_immediate = 8'h10;
        tick(ST_EXECUTE);
        tick(ST_EXECUTE);
        check("call_full_npc", next_pc, 8'h10);
        check("call_full_err", stack_error, 1);
        tick(ST_UPDATE);
        clear_ctl();
        for (int i = 0; i < 4; i++) begin
            decoded_ret = 1'b1;
            tick(ST_EXECUTE);
            tick(ST_EXECUTE);
            check("ret_npc", next_pc, 6 - i);
            tick(ST_UPDATE);
        end
        tick(ST_EXECUTE);
        check("ret_empty_npc", next_pc, 4);
        check("err_sticky", stack_error, 1);
        clear_ctl();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
